// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one single-ported data memory between the MEM stage (port 0)
// and a secondary requester (port 1), with busywait tracking and an access timeout.
module dmem_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic              Clock,
    input  logic              Reset,

    input  logic              p0_Read,
    input  logic              p0_Write,
    input  logic [ADDR_W-1:0] p0_Address,
    input  logic [DATA_W-1:0] p0_Write_data,
    input  logic [2:0]        p0_Func3,
    output logic [DATA_W-1:0] p0_Read_data,
    output logic              p0_busywait,
    output logic              p0_error,

    input  logic              p1_Read,
    input  logic              p1_Write,
    input  logic [ADDR_W-1:0] p1_Address,
    input  logic [DATA_W-1:0] p1_Write_data,
    input  logic [2:0]        p1_Func3,
    output logic [DATA_W-1:0] p1_Read_data,
    output logic              p1_busywait,
    output logic              p1_error,

    output logic              mem_Read,
    output logic              mem_Write,
    output logic [ADDR_W-1:0] mem_Address,
    output logic [DATA_W-1:0] mem_Write_data,
    output logic [2:0]        mem_Func3,
    input  logic [DATA_W-1:0] mem_Read_data,
    input  logic              mem_busywait
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state;
    state_t            state_next;
    logic              grant;
    logic              last_grant;
    logic [CNT_W-1:0]  wait_cnt;

    logic              p0_req;
    logic              p1_req;
    logic              start;
    logic              pick;
    logic              complete;
    logic              timeout;

    logic              sel_read;
    logic              sel_write;
    logic [ADDR_W-1:0] sel_address;
    logic [DATA_W-1:0] sel_write_data;
    logic [2:0]        sel_func3;
    logic [DATA_W-1:0] load_value;

    assign p0_req = p0_Read | p0_Write;
    assign p1_req = p1_Read | p1_Write;

    // The granted port sees busywait drop only during its DONE cycle.
    assign p0_busywait = p0_req & ~((state == DONE) & ~grant);
    assign p1_busywait = p1_req & ~((state == DONE) &  grant);

    assign sel_read       = pick ? p1_Read       : p0_Read;
    assign sel_write      = pick ? p1_Write      : p0_Write;
    assign sel_address    = pick ? p1_Address    : p0_Address;
    assign sel_write_data = pick ? p1_Write_data : p0_Write_data;
    assign sel_func3      = pick ? p1_Func3      : p0_Func3;

    assign load_value = timeout ? '0 : mem_Read_data;

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        start      = 1'b0;
        pick       = 1'b0;
        complete   = 1'b0;
        timeout    = 1'b0;
        case (state)
            IDLE: begin
                if (p0_req || p1_req) begin
                    start      = 1'b1;
                    pick       = (p0_req && p1_req) ? ~last_grant : p1_req;
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                // wait_cnt != 0 guards against a stale busywait-low before the memory sees the strobe.
                if (!mem_busywait && wait_cnt != '0) begin
                    complete   = 1'b1;
                    state_next = DONE;
                end else if (mem_busywait && wait_cnt == CNT_LAST) begin
                    timeout    = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            grant          <= 1'b0;
            last_grant     <= 1'b1;
            wait_cnt       <= '0;
            mem_Read       <= 1'b0;
            mem_Write      <= 1'b0;
            mem_Address    <= '0;
            mem_Write_data <= '0;
            mem_Func3      <= '0;
            p0_Read_data   <= '0;
            p1_Read_data   <= '0;
            p0_error       <= 1'b0;
            p1_error       <= 1'b0;
        end else begin
            p0_error <= 1'b0;
            p1_error <= 1'b0;

            if (start) begin
                grant          <= pick;
                last_grant     <= pick;
                wait_cnt       <= '0;
                mem_Read       <= sel_read;
                mem_Write      <= sel_write & ~sel_read;
                mem_Address    <= sel_address;
                mem_Write_data <= sel_write_data;
                mem_Func3      <= sel_func3;
            end else if (state == ACCESS && wait_cnt != CNT_MAX) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end

            if (complete || timeout) begin
                mem_Read  <= 1'b0;
                mem_Write <= 1'b0;
                if (mem_Read) begin
                    if (grant) begin
                        p1_Read_data <= load_value;
                    end else begin
                        p0_Read_data <= load_value;
                    end
                end
                if (timeout) begin
                    if (grant) begin
                        p1_error <= 1'b1;
                    end else begin
                        p0_error <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a byte-addressed memory model with a strobe-triggered
// busywait handshake (and a hang mode) sits behind the arbiter.
module tb_dmem_arbiter;

    localparam int TIMEOUT = 16;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;

    logic        p0_Read = 1'b0, p0_Write = 1'b0;
    logic [31:0] p0_Address = '0, p0_Write_data = '0;
    logic [2:0]  p0_Func3 = '0;
    logic [31:0] p0_Read_data;
    logic        p0_busywait, p0_error;

    logic        p1_Read = 1'b0, p1_Write = 1'b0;
    logic [31:0] p1_Address = '0, p1_Write_data = '0;
    logic [2:0]  p1_Func3 = '0;
    logic [31:0] p1_Read_data;
    logic        p1_busywait, p1_error;

    logic        mem_Read, mem_Write;
    logic [31:0] mem_Address, mem_Write_data;
    logic [2:0]  mem_Func3;
    logic [31:0] mem_Read_data = '0;
    logic        mem_busywait;

    logic        hang = 1'b0;
    logic        ack = 1'b0;
    logic [7:0]  mem_bytes [0:255];

    int n_compared   = 0;
    int n_mismatched = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Reset(Reset),
        .p0_Read(p0_Read), .p0_Write(p0_Write), .p0_Address(p0_Address),
        .p0_Write_data(p0_Write_data), .p0_Func3(p0_Func3), .p0_Read_data(p0_Read_data),
        .p0_busywait(p0_busywait), .p0_error(p0_error),
        .p1_Read(p1_Read), .p1_Write(p1_Write), .p1_Address(p1_Address),
        .p1_Write_data(p1_Write_data), .p1_Func3(p1_Func3), .p1_Read_data(p1_Read_data),
        .p1_busywait(p1_busywait), .p1_error(p1_error),
        .mem_Read(mem_Read), .mem_Write(mem_Write), .mem_Address(mem_Address),
        .mem_Write_data(mem_Write_data), .mem_Func3(mem_Func3),
        .mem_Read_data(mem_Read_data), .mem_busywait(mem_busywait)
    );

    always #5 Clock = ~Clock;

    // Memory model: busy from strobe rise until its first edge, then acknowledged until strobes drop.
    assign mem_busywait = (mem_Read | mem_Write) & (hang | ~ack);

    always @(posedge Clock) begin
        logic [7:0]  a;
        logic [31:0] w;
        a = mem_Address[7:0];
        if (!(mem_Read || mem_Write)) begin
            ack <= 1'b0;
        end else if (!ack && !hang) begin
            ack <= 1'b1;
            w = {mem_bytes[a + 8'd3], mem_bytes[a + 8'd2], mem_bytes[a + 8'd1], mem_bytes[a]};
            if (mem_Read) begin
                case (mem_Func3)
                    3'b000:  mem_Read_data <= {{24{w[7]}}, w[7:0]};
                    3'b001:  mem_Read_data <= {{16{w[15]}}, w[15:0]};
                    3'b100:  mem_Read_data <= {24'b0, w[7:0]};
                    3'b101:  mem_Read_data <= {16'b0, w[15:0]};
                    default: mem_Read_data <= w;
                endcase
            end else begin
                mem_bytes[a] <= mem_Write_data[7:0];
                if (mem_Func3[1:0] != 2'b00) mem_bytes[a + 8'd1] <= mem_Write_data[15:8];
                if (mem_Func3[1:0] == 2'b10) begin
                    mem_bytes[a + 8'd2] <= mem_Write_data[23:16];
                    mem_bytes[a + 8'd3] <= mem_Write_data[31:24];
                end
            end
        end
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic set_port(input int port, input logic rd, input logic wr,
                            input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3);
        if (port == 0) begin
            p0_Read = rd; p0_Write = wr; p0_Address = addr; p0_Write_data = wd; p0_Func3 = f3;
        end else begin
            p1_Read = rd; p1_Write = wr; p1_Address = addr; p1_Write_data = wd; p1_Func3 = f3;
        end
    endtask

    function automatic logic port_busy(input int port);
        return (port == 0) ? p0_busywait : p1_busywait;
    endfunction

    // Raises a request in cycle 0 and returns at the negedge of the cycle busywait is first low.
    task automatic applyStimulus(input int port, input logic rd, input logic wr,
                                 input logic [31:0] addr, input logic [31:0] wd, input logic [2:0] f3,
                                 output int lat, output logic [2:0] seen_f3, output logic seen_wr);
        @(posedge Clock);
        #1;
        set_port(port, rd, wr, addr, wd, f3);
        lat     = -1;
        seen_f3 = 3'b111;
        seen_wr = 1'bx;
        for (int cyc = 0; cyc < 64; cyc++) begin
            @(negedge Clock);
            if (cyc == 1) begin
                seen_f3 = mem_Func3;
                seen_wr = mem_Write;
            end
            if (!port_busy(port)) begin
                lat = cyc;
                break;
            end
        end
        set_port(port, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
    endtask

    task automatic doReset();
        Reset = 1'b1;
        set_port(0, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        repeat (2) @(posedge Clock);
        #1;
        Reset = 1'b0;
    endtask

    task automatic bothRequest(output int d0, output int d1);
        @(posedge Clock);
        #1;
        set_port(0, 1'b0, 1'b1, 32'h10, 32'h1111_1111, 3'b010);
        set_port(1, 1'b0, 1'b1, 32'h20, 32'h2222_2222, 3'b010);
        d0 = -1;
        d1 = -1;
        for (int cyc = 0; cyc < 64 && (d0 < 0 || d1 < 0); cyc++) begin
            @(negedge Clock);
            if (d0 < 0 && !p0_busywait) begin d0 = cyc; p0_Write = 1'b0; end
            if (d1 < 0 && !p1_busywait) begin d1 = cyc; p1_Write = 1'b0; end
        end
        p0_Write = 1'b0;
        p1_Write = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int       lat, d0, d1, n;
        logic [2:0] f3;
        logic     wr;
        int       order [8];

        for (int i = 0; i < 256; i++) mem_bytes[i] = 8'h00;

        doReset();
        @(negedge Clock);
        checkOutput("rst_mem_read",   {31'b0, mem_Read},  32'h0);
        checkOutput("rst_mem_write",  {31'b0, mem_Write}, 32'h0);
        checkOutput("rst_mem_addr",   mem_Address,        32'h0);
        checkOutput("rst_mem_f3",     {29'b0, mem_Func3}, 32'h0);
        checkOutput("rst_p0_rdata",   p0_Read_data,       32'h0);
        checkOutput("rst_p1_rdata",   p1_Read_data,       32'h0);
        checkOutput("rst_p0_error",   {31'b0, p0_error},  32'h0);
        checkOutput("rst_p0_busy",    {31'b0, p0_busywait}, 32'h0);

        applyStimulus(0, 1'b0, 1'b1, 32'h40, 32'hDEAD_BEEF, 3'b010, lat, f3, wr);
        checkOutput("sw_latency", 32'(lat), 32'd3);
        checkOutput("sw_func3",   {29'b0, f3}, 32'h2);
        checkOutput("sw_strobe",  {31'b0, wr}, 32'h1);
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, lat, f3, wr);
        checkOutput("lw_latency", 32'(lat), 32'd3);
        checkOutput("lw_data",    p0_Read_data, 32'hDEAD_BEEF);

        applyStimulus(0, 1'b0, 1'b1, 32'h44, 32'hCAFE_F00D, 3'b010, lat, f3, wr);
        checkOutput("sw_keeps_rdata", p0_Read_data, 32'hDEAD_BEEF);

        applyStimulus(0, 1'b1, 1'b1, 32'h40, 32'h1234_5678, 3'b010, lat, f3, wr);
        checkOutput("rdwr_no_write", {31'b0, wr}, 32'h0);
        checkOutput("rdwr_data",     p0_Read_data, 32'hDEAD_BEEF);
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, lat, f3, wr);
        checkOutput("rdwr_mem_kept", p0_Read_data, 32'hDEAD_BEEF);

        applyStimulus(1, 1'b0, 1'b1, 32'h41, 32'h0000_0080, 3'b000, lat, f3, wr);
        checkOutput("sb_func3", {29'b0, f3}, 32'h0);
        applyStimulus(1, 1'b1, 1'b0, 32'h41, 32'h0, 3'b000, lat, f3, wr);
        checkOutput("lb_func3", {29'b0, f3}, 32'h0);
        checkOutput("lb_data",  p1_Read_data, 32'hFFFF_FF80);
        applyStimulus(1, 1'b1, 1'b0, 32'h41, 32'h0, 3'b100, lat, f3, wr);
        checkOutput("lbu_func3", {29'b0, f3}, 32'h4);
        checkOutput("lbu_data",  p1_Read_data, 32'h0000_0080);
        checkOutput("p0_rdata_untouched", p0_Read_data, 32'hDEAD_BEEF);

        hang = 1'b1;
        applyStimulus(0, 1'b1, 1'b0, 32'h40, 32'h0, 3'b010, lat, f3, wr);
        checkOutput("to_latency",  32'(lat), 32'(TIMEOUT + 1));
        checkOutput("to_error",    {31'b0, p0_error}, 32'h1);
        checkOutput("to_p1_error", {31'b0, p1_error}, 32'h0);
        checkOutput("to_rdata",    p0_Read_data, 32'h0);
        checkOutput("to_strobe",   {31'b0, mem_Read}, 32'h0);
        @(negedge Clock);
        checkOutput("to_pulse_end", {31'b0, p0_error}, 32'h0);
        hang = 1'b0;
        applyStimulus(0, 1'b1, 1'b0, 32'h44, 32'h0, 3'b010, lat, f3, wr);
        checkOutput("after_to_latency", 32'(lat), 32'd3);
        checkOutput("after_to_data",    p0_Read_data, 32'hCAFE_F00D);

        doReset();
        bothRequest(d0, d1);
        checkOutput("sim_p0_done", 32'(d0), 32'd3);
        checkOutput("sim_p1_done", 32'(d1), 32'd7);
        applyStimulus(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, lat, f3, wr);
        checkOutput("sim_p1_data", p1_Read_data, 32'h2222_2222);

        doReset();
        for (int i = 0; i < 8; i++) order[i] = -1;
        n = 0;
        @(posedge Clock);
        #1;
        set_port(0, 1'b0, 1'b1, 32'h80, 32'hA0A0_A0A0, 3'b010);
        set_port(1, 1'b0, 1'b1, 32'h90, 32'hB1B1_B1B1, 3'b010);
        for (int cyc = 0; cyc < 200 && n < 8; cyc++) begin
            @(negedge Clock);
            if (p0_Write && !p0_busywait) begin
                order[n] = 0; n++; p0_Write = 1'b0;
            end else if (p1_Write && !p1_busywait) begin
                order[n] = 1; n++; p1_Write = 1'b0;
            end
            @(posedge Clock);
            #1;
            if (n < 8) begin
                p0_Write = 1'b1;
                p1_Write = 1'b1;
            end
        end
        p0_Write = 1'b0;
        p1_Write = 1'b0;
        checkOutput("fair_count", 32'(n), 32'd8);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("fair_order%0d", i), 32'(order[i]), 32'(i % 2));
        end

        @(posedge Clock);
        #1;
        set_port(1, 1'b0, 1'b1, 32'h60, 32'h5555_5555, 3'b010);
        @(negedge Clock);
        @(negedge Clock);
        checkOutput("mid_write_active", {31'b0, mem_Write}, 32'h1);
        Reset = 1'b1;
        #1;
        checkOutput("mid_write_dropped", {31'b0, mem_Write}, 32'h0);
        checkOutput("mid_addr_cleared",  mem_Address,        32'h0);
        checkOutput("mid_p1_pending",    {31'b0, p1_busywait}, 32'h1);
        set_port(1, 1'b0, 1'b0, 32'h0, 32'h0, 3'b000);
        @(posedge Clock);
        #1;
        Reset = 1'b0;
        bothRequest(d0, d1);
        checkOutput("mid_p0_first", 32'(d0), 32'd3);
        checkOutput("mid_p1_next",  32'(d1), 32'd7);

        repeat (2) @(posedge Clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Two-port arbiter that shares the single-ported data memory between the pipeline's MEM stage (port 0) and a second requester such as the program loader or debug port (port 1). It grants one load/store at a time using round-robin arbitration. It forwards the granted request to the memory's Read/Write/Address/Write_data/Func3 inputs and tracks the memory busywait handshake. It returns the result to the granted port with a per-port busywait and a timeout error. It sits between the MEM-stage/loader and the data memory, and is the only block that drives the memory's request inputs.

## Interface
- ADDR_W, 32, address width on both ports and memory side
- DATA_W, 32, data width
- TIMEOUT, 16, maximum ACCESS cycles before abort; must be ≥ 2
- Clock  in  1  single clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high; clears all state immediately
- pN_Read, pN_Write  in  1 each (N = 0,1)  request strobes, held until completion
- pN_Address  in  ADDR_W  byte address
- pN_Write_data  in  DATA_W  store data
- pN_Func3  in  3  RV32 load/store funct3, passed through unchanged
- pN_Read_data  out  DATA_W  registered load result, held until the port's next load completes
- pN_busywait  out  1  high while port N has a request pending
- pN_error  out  1  one-cycle pulse when port N's access timed out
- mem_Read, mem_Write  out  1  registered strobes to data memory
- mem_Address, mem_Write_data, mem_Func3  out  registered copies of the granted request
- mem_Read_data  in  DATA_W  memory read result
- mem_busywait  in  1  memory busy flag; rises combinationally with a strobe and falls after the memory's clock edge

## Operation
- FSM states are IDLE, ACCESS and DONE.
- On reset:
  - state = IDLE; mem strobes = 0; mem_Address, mem_Write_data and mem_Func3 = 0.
  - pN_Read_data = 0 and pN_error = 0.
  - wait_cnt = 0; grant = 0; last_grant = 1, so port 0 wins first.
- A port is requesting when pN_Read or pN_Write is high. If both are high, the request is treated as a read and the Write strobe is dropped.
- pN_busywait = requesting AND NOT (state == DONE AND grant == N). This is combinational, so it rises in the same cycle as the request.
- IDLE:
  - With no request, stay in IDLE.
  - With exactly one request, grant that port.
  - With both requesting, grant the port ≠ last_grant.
  - On grant, register the granted port's Address, Write_data and Func3 onto the mem_* outputs.
  - On grant, set exactly one mem strobe, clear wait_cnt, update last_grant, and move to ACCESS.
- ACCESS:
  - mem strobes and mem_* fields stay stable.
  - wait_cnt increments each edge and saturates at TIMEOUT.
  - Completion when mem_busywait == 0 AND wait_cnt ≠ 0:
    - For a read, capture mem_Read_data into the granted port's pN_Read_data. A write leaves pN_Read_data unchanged.
    - Clear mem strobes and move to DONE.
  - Timeout when wait_cnt == TIMEOUT−1 AND mem_busywait == 1 at the edge:
    - Clear mem strobes.
    - For a read, set the granted port's pN_Read_data = 0.
    - Pulse pN_error in the DONE cycle and move to DONE.
- DONE:
  - Lasts one cycle. The granted port sees busywait low and must drop its strobes before the next edge.
  - Move to IDLE. A request still held at the IDLE edge is a new access.
- The non-granted port's request is held pending, with busywait high, and is never dropped.
- The mem strobes are low for at least 2 cycles (DONE + IDLE) between accesses, so the memory's strobe-sensitive busywait logic retriggers.
- Reset asserted mid-access forces IDLE asynchronously and drops the strobes. Memory contents are not the arbiter's concern.

## Timing
- Cycle k is the interval after rising edge k.
- Single read or write with idle memory:
  - Request raised in cycle 0; grant at edge 1.
  - Strobe high in cycles 1–2; memory operates at edge 2.
  - Capture at edge 3; DONE in cycle 3; IDLE in cycle 4.
  - Port latency: busywait falls 3 cycles after the request.
- Back-to-back requests from the same port are spaced 4 cycles apart.
- With both ports continuously requesting, grants alternate every 4 cycles.
- Timeout: a DONE cycle with pN_error = 1 occurs TIMEOUT cycles after grant.

## Test plan
- Reset, then p0 word store, then load: p0 stores 0xDEADBEEF to 0x40 with Func3 = 010, then loads 0x40 with Func3 = 010. Required: p0_Read_data = 0xDEADBEEF; each p0_busywait falls exactly 3 cycles after its request.
- Simultaneous requests: p0 and p1 both request from reset. Required: p0 is granted first, p1 completes 4 cycles later, and p1_busywait stays high throughout.
- Fairness: both ports hold requests for 8 accesses. Required: grant order p0,p1,p0,p1…, and neither port ever receives two grants in a row.
- Sub-word access: p1 issues SB of 0x80 to 0x41, then LB of 0x41, then LBU of 0x41. Required: p1_Read_data = 0xFFFFFF80, then 0x00000080. Func3 is seen unchanged on mem_Func3.
- Timeout: a memory model holds busywait high forever and p0 issues a load. Required: p0_error pulses once at cycle TIMEOUT, p0_Read_data = 0, and the arbiter returns to IDLE.
- Mid-access reset: Reset is asserted in cycle 1 of a p1 write. Required: mem_Write = 0 and state = IDLE immediately, with no clock edge needed. After release, p0 is granted first.
